stopwatch_digits: RTL and testbench

- Stopwatch core counting mm:ss from 00:00 to 59:59 from a prescaled 1 Hz tick.
- Sits directly upstream of the 4-digit multiplexed 7-segment display driver. Its dig3..dig0 BCD outputs feed that driver's digit inputs one-to-one (dig3 = minutes tens).
- Handles the three front-panel keys (start/pause, clear, lap) with synchronisation and rising-edge detection.
- Emits the display's blank code (4'hD) for leading-zero suppression.

---
 rtl/stopwatch_digits.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_digits.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_digits.sv
// mm:ss stopwatch core: synchronised front-panel keys, run/pause/overflow control,
// BCD cascade counter, lap freeze and leading-zero blanking for a 4-digit display.
module stopwatch_digits #(
  parameter int TICK_DIV = 50_000_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_clr,
  input  logic       key_lap,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       running,
  output logic       overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] BLANK_CODE = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVF   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    minTens_q, minTens_d;
  logic [3:0]    minUnits_q, minUnits_d;
  logic [3:0]    secTens_q, secTens_d;
  logic [3:0]    secUnits_q, secUnits_d;
  logic [15:0]   lap_q, lap_d;
  logic          frozen_q, frozen_d;

  // Key bit order everywhere: {lap, clr, start}
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] keyPulse;
  logic       startPulse, clrPulse, lapPulse;

  logic        tick;
  logic        atMax;
  logic [15:0] liveCount;
  logic [15:0] shownCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {key_lap, key_clr, key_start};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // clr discards start and lap in the same cycle; start in turn discards lap.
  assign keyPulse   = sync2_q & ~prev_q;
  assign clrPulse   = keyPulse[1];
  assign startPulse = keyPulse[0] & ~keyPulse[1];
  assign lapPulse   = keyPulse[2] & ~keyPulse[1] & ~keyPulse[0];

  assign liveCount = {minTens_q, minUnits_q, secTens_q, secUnits_q};
  assign atMax     = (liveCount == 16'h5959);
  assign tick      = (presc_q == PRESC_LAST) && (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    minTens_d  = minTens_q;
    minUnits_d = minUnits_q;
    secTens_d  = secTens_q;
    secUnits_d = secUnits_q;
    lap_d      = lap_q;
    frozen_d   = frozen_q;

    case (state_q)
      RUN:     presc_d = tick ? '0 : presc_q + PW'(1);
      PAUSE:   presc_d = presc_q;
      default: presc_d = '0;
    endcase

    // The whole carry chain resolves in one edge, e.g. 09:59 -> 10:00.
    if (tick && !atMax) begin
      if (secUnits_q == 4'd9) begin
        secUnits_d = 4'd0;
        if (secTens_q == 4'd5) begin
          secTens_d = 4'd0;
          if (minUnits_q == 4'd9) begin
            minUnits_d = 4'd0;
            minTens_d  = minTens_q + 4'd1;
          end else begin
            minUnits_d = minUnits_q + 4'd1;
          end
        end else begin
          secTens_d = secTens_q + 4'd1;
        end
      end else begin
        secUnits_d = secUnits_q + 4'd1;
      end
    end

    case (state_q)
      IDLE:  if (startPulse) state_d = RUN;
      RUN: begin
        if (startPulse)        state_d = PAUSE;
        else if (tick && atMax) state_d = OVF;
      end
      PAUSE: if (startPulse) state_d = RUN;
      default: state_d = state_q;
    endcase

    if (lapPulse) begin
      if (frozen_q) begin
        frozen_d = 1'b0;
      end else if (state_q == RUN) begin
        lap_d    = liveCount;
        frozen_d = 1'b1;
      end
    end

    if (clrPulse) begin
      state_d    = IDLE;
      presc_d    = '0;
      minTens_d  = 4'd0;
      minUnits_d = 4'd0;
      secTens_d  = 4'd0;
      secUnits_d = 4'd0;
      frozen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      minTens_q  <= 4'd0;
      minUnits_q <= 4'd0;
      secTens_q  <= 4'd0;
      secUnits_q <= 4'd0;
      lap_q      <= 16'h0000;
      frozen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      minTens_q  <= minTens_d;
      minUnits_q <= minUnits_d;
      secTens_q  <= secTens_d;
      secUnits_q <= secUnits_d;
      lap_q      <= lap_d;
      frozen_q   <= frozen_d;
    end
  end

  assign shownCount = frozen_q ? lap_q : liveCount;
  assign dig3 = (BLANK_LZ && (shownCount[15:12] == 4'd0)) ? BLANK_CODE : shownCount[15:12];
  assign dig2 = shownCount[11:8];
  assign dig1 = shownCount[7:4];
  assign dig0 = shownCount[3:0];

  assign running  = (state_q == RUN);
  assign overflow = (state_q == OVF);

endmodule

// File: tb/tb_stopwatch_digits.sv
// Scenario bench for stopwatch_digits (TICK_DIV=4, BLANK_LZ=1): expected digit
// words are queued as each scenario drives its keys and popped at the sample points.
module tb_stopwatch_digits;

  localparam int K_START = 0;
  localparam int K_CLR   = 1;
  localparam int K_LAP   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start, key_clr, key_lap;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       running, overflow;

  int          total = 0;
  int          bad = 0;
  logic [15:0] expQ[$];
  logic [15:0] expW, gotW;

  stopwatch_digits #(.TICK_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start(key_start), .key_clr(key_clr), .key_lap(key_lap),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key high for exactly one rising edge; returns on the falling edge after the action edge.
  task automatic pressKey(input int which);
    case (which)
      K_START: key_start = 1'b1;
      K_CLR:   key_clr = 1'b1;
      default: key_lap = 1'b1;
    endcase
    @(negedge clk);
    key_start = 1'b0;
    key_clr   = 1'b0;
    key_lap   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearAndStart();
    pressKey(K_CLR);
    pressKey(K_START);
  endtask

  task automatic test_reset();
    expQ.push_back(16'hD000);
    rst_n = 1'b0;
    key_start = 1'b0;
    key_clr = 1'b0;
    key_lap = 1'b0;
    waitCycles(2);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL reset_digits: got %h expected %h", gotW, expW); end
    total++;
    if ({running, overflow} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 00", {running, overflow}); end
    rst_n = 1'b1;
    waitCycles(1);
  endtask

  task automatic test_start_single();
    expQ.push_back(16'hD000);
    expQ.push_back(16'hD001);
    expQ.push_back(16'hD010);
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    @(negedge clk);
    total++;
    if (running !== 1'b0) begin bad++; $display("[TB] FAIL start_early: got %b expected 0", running); end
    @(negedge clk);
    total++;
    if (running !== 1'b1) begin bad++; $display("[TB] FAIL start_edge3: got %b expected 1", running); end
    waitCycles(3);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL first_step_e3: got %h expected %h", gotW, expW); end
    waitCycles(1);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL first_step_e4: got %h expected %h", gotW, expW); end
    waitCycles(36);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b1) begin
      bad++; $display("[TB] FAIL run_40clk: got %h run=%b expected %h run=1", gotW, running, expW);
    end
  endtask

  task automatic test_carry();
    expQ.push_back(16'hD959);
    expQ.push_back(16'h1000);
    clearAndStart();
    waitCycles(2399);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL carry_before: got %h expected %h", gotW, expW); end
    waitCycles(1);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL carry_0959: got %h expected %h", gotW, expW); end
  endtask

  task automatic test_overflow();
    expQ.push_back(16'h5959);
    expQ.push_back(16'h5959);
    expQ.push_back(16'h5959);
    expQ.push_back(16'hD000);
    clearAndStart();
    waitCycles(14399);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b1) begin
      bad++; $display("[TB] FAIL at_5959: got %h run=%b expected %h run=1", gotW, running, expW);
    end
    waitCycles(1);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || {running, overflow} !== 2'b01) begin
      bad++; $display("[TB] FAIL ovf_enter: got %h run/ovf=%b expected %h 01", gotW, {running, overflow}, expW);
    end
    pressKey(K_START);
    waitCycles(10);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || {running, overflow} !== 2'b01) begin
      bad++; $display("[TB] FAIL ovf_start_ignored: got %h run/ovf=%b expected %h 01", gotW, {running, overflow}, expW);
    end
    pressKey(K_CLR);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || {running, overflow} !== 2'b00) begin
      bad++; $display("[TB] FAIL ovf_clr: got %h run/ovf=%b expected %h 00", gotW, {running, overflow}, expW);
    end
  endtask

  task automatic test_lap();
    expQ.push_back(16'hD007);
    expQ.push_back(16'hD007);
    expQ.push_back(16'hD027);
    expQ.push_back(16'hD028);
    clearAndStart();
    waitCycles(28);
    pressKey(K_LAP);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL lap_capture: got %h expected %h", gotW, expW); end
    waitCycles(77);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL lap_frozen: got %h expected %h", gotW, expW); end
    pressKey(K_LAP);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL lap_release: got %h expected %h", gotW, expW); end
    waitCycles(1);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL lap_live: got %h expected %h", gotW, expW); end
  endtask

  task automatic test_pause();
    expQ.push_back(16'hD003);
    expQ.push_back(16'hD003);
    expQ.push_back(16'hD003);
    expQ.push_back(16'hD004);
    expQ.push_back(16'hD005);
    clearAndStart();
    waitCycles(12);
    pressKey(K_START);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b0) begin
      bad++; $display("[TB] FAIL pause_enter: got %h run=%b expected %h run=0", gotW, running, expW);
    end
    waitCycles(100);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL pause_hold: got %h expected %h", gotW, expW); end
    pressKey(K_START);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b1) begin
      bad++; $display("[TB] FAIL resume: got %h run=%b expected %h run=1", gotW, running, expW);
    end
    waitCycles(1);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL resume_phase: got %h expected %h", gotW, expW); end
    waitCycles(4);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL resume_next: got %h expected %h", gotW, expW); end
  endtask

  task automatic test_back_to_back();
    expQ.push_back(16'hD000);
    expQ.push_back(16'hD000);
    clearAndStart();
    waitCycles(10);
    key_clr = 1'b1;
    key_start = 1'b1;
    @(negedge clk);
    key_clr = 1'b0;
    key_start = 1'b0;
    waitCycles(2);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_start_same: got %h run=%b expected %h run=0", gotW, running, expW);
    end
    waitCycles(12);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_start_idle: got %h run=%b expected %h run=0", gotW, running, expW);
    end
  endtask

  task automatic test_held_key();
    expQ.push_back(16'hD002);
    expQ.push_back(16'hD003);
    pressKey(K_CLR);
    key_start = 1'b1;
    waitCycles(12);
    key_start = 1'b0;
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b1) begin
      bad++; $display("[TB] FAIL held_start: got %h run=%b expected %h run=1", gotW, running, expW);
    end
    waitCycles(4);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL held_release: got %h expected %h", gotW, expW); end
  endtask

  task automatic test_async_reset();
    expQ.push_back(16'hD008);
    expQ.push_back(16'hD000);
    expQ.push_back(16'hD000);
    clearAndStart();
    waitCycles(30);
    pressKey(K_LAP);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW) begin bad++; $display("[TB] FAIL pre_reset_lap: got %h expected %h", gotW, expW); end
    #2 rst_n = 1'b0;
    #1;
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || {running, overflow} !== 2'b00) begin
      bad++; $display("[TB] FAIL async_reset: got %h run/ovf=%b expected %h 00", gotW, {running, overflow}, expW);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(8);
    expW = expQ.pop_front(); gotW = {dig3, dig2, dig1, dig0}; total++;
    if (gotW !== expW || running !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_idle: got %h run=%b expected %h run=0", gotW, running, expW);
    end
  endtask

  initial begin
    test_reset();
    test_start_single();
    test_carry();
    test_overflow();
    test_lap();
    test_pause();
    test_back_to_back();
    test_held_key();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
